// File: rtl/rx_pkg.sv
// Shared types and helpers for the serial receiver: state encoding,
// mid-bit sample offset and the parity rule used by both link ends.
package rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  // Offset of the sample point inside a bit period (floor of the midpoint).
  function automatic int half_bit(input int clks_per_bit);
    return (clks_per_bit - 1) / 2;
  endfunction

  // Parity bit for a word whose bits XOR to data_xor; even=1 selects even parity.
  function automatic logic parity_bit(input logic data_xor, input logic even);
    return even ? data_xor : ~data_xor;
  endfunction

endpackage

// File: rtl/fsm_rx.sv
// Receiver control: state register, cycle/bit counters and sample strobes.
// The strobes mark the exact cycle each frame bit is taken from the line.
module fsm_rx
  import rx_pkg::*;
#(
  parameter int N            = 8,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rx_s_i,
  input  logic      par_en_i,
  input  logic      par_even_i,
  output rx_state_t state_o,
  output logic      par_even_o,
  output logic      start_o,
  output logic      data_smp_o,
  output logic      par_smp_o,
  output logic      stop_smp_o
);

  localparam int H  = half_bit(CLKS_PER_BIT);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(N + 1);

  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_CNT = CW'((H > 0) ? H - 1 : 0);
  localparam logic [BW-1:0] LAST_BIT = BW'(N - 1);

  rx_state_t         state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic              armed_q, armed_d;
  logic              par_en_q, par_en_d;
  logic              par_even_q, par_even_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      armed_q    <= 1'b1;
      par_en_q   <= 1'b0;
      par_even_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      armed_q    <= armed_d;
      par_en_q   <= par_en_d;
      par_even_q <= par_even_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    armed_d    = armed_q;
    par_en_d   = par_en_q;
    par_even_d = par_even_q;
    start_o    = 1'b0;
    data_smp_o = 1'b0;
    par_smp_o  = 1'b0;
    stop_smp_o = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (armed_q) begin
          if (!rx_s_i) begin
            start_o    = 1'b1;
            par_en_d   = par_en_i;
            par_even_d = par_even_i;
            // With a one-cycle sample offset of zero the start bit is already confirmed.
            state_d    = (H == 0) ? DATA : START;
          end
        end else if (rx_s_i) begin
          armed_d = 1'b1;
        end
      end

      START: begin
        if (cnt_q == HALF_CNT) begin
          cnt_d   = '0;
          state_d = rx_s_i ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      DATA: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d      = '0;
          data_smp_o = 1'b1;
          if (bit_q == LAST_BIT) begin
            bit_d   = '0;
            state_d = par_en_q ? PARITY : STOP;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      PARITY: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d     = '0;
          par_smp_o = 1'b1;
          state_d   = STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      STOP: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d      = '0;
          stop_smp_o = 1'b1;
          // A low stop bit means a break: wait for the line to rise before rearming.
          armed_d    = rx_s_i;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign state_o    = state_q;
  assign par_even_o = par_even_q;

endmodule

// File: rtl/dataflow_rx.sv
// Serial receiver top: line conditioning, data shift register, parity check
// and registered result pulses. Optional macro RX_SYNC_EN adds a 2-flop input synchroniser.
module dataflow_rx
  import rx_pkg::*;
#(
  parameter int n            = 8,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         Rx,
  input  logic         parity_check,
  input  logic         parity_type_even_odd,
  output logic [n-1:0] D_out,
  output logic         valid,
  output logic         parity_err,
  output logic         frame_err,
  output logic         busy
);

  logic rx_s;

`ifdef RX_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge clk) begin
    if (rst) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], Rx};
  end
  assign rx_s = sync_q[1];
`else
  assign rx_s = Rx;
`endif

  rx_state_t state;
  logic      par_even;
  logic      start_smp, data_smp, par_smp, stop_smp;

  fsm_rx #(
    .N           (n),
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_fsm (
    .clk       (clk),
    .rst       (rst),
    .rx_s_i    (rx_s),
    .par_en_i  (parity_check),
    .par_even_i(parity_type_even_odd),
    .state_o   (state),
    .par_even_o(par_even),
    .start_o   (start_smp),
    .data_smp_o(data_smp),
    .par_smp_o (par_smp),
    .stop_smp_o(stop_smp)
  );

  logic [n-1:0] sh_q, sh_d;
  logic [n-1:0] dout_q, dout_d;
  logic         acc_q, acc_d;
  logic         perr_q, perr_d;
  logic         valid_q, valid_d;
  logic         pe_q, pe_d;
  logic         fe_q, fe_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q    <= '0;
      dout_q  <= '0;
      acc_q   <= 1'b0;
      perr_q  <= 1'b0;
      valid_q <= 1'b0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      sh_q    <= sh_d;
      dout_q  <= dout_d;
      acc_q   <= acc_d;
      perr_q  <= perr_d;
      valid_q <= valid_d;
      pe_q    <= pe_d;
      fe_q    <= fe_d;
    end
  end

  always_comb begin
    sh_d    = sh_q;
    dout_d  = dout_q;
    acc_d   = acc_q;
    perr_d  = perr_q;
    valid_d = 1'b0;
    pe_d    = 1'b0;
    fe_d    = 1'b0;

    if (start_smp) begin
      acc_d  = 1'b0;
      perr_d = 1'b0;
    end

    // Data arrives LSB first, so each new bit enters at the top and moves down.
    if (data_smp) begin
      for (int i = 0; i < n - 1; i++) sh_d[i] = sh_q[i+1];
      sh_d[n-1] = rx_s;
      acc_d     = acc_q ^ rx_s;
    end

    if (par_smp) perr_d = (rx_s != parity_bit(acc_q, par_even));

    if (stop_smp) begin
      dout_d  = sh_q;
      valid_d = rx_s & ~perr_q;
      pe_d    = perr_q;
      fe_d    = ~rx_s;
    end
  end

  assign D_out      = dout_q;
  assign valid      = valid_q;
  assign parity_err = pe_q;
  assign frame_err  = fe_q;
  assign busy       = (state != IDLE);

endmodule
